// File: rtl/axil_pkg.sv
// axil_pkg: definitions shared by the AXI4-Lite adder master and the adder slave.
//   - state_t      : master FSM state encoding (also exported on state_dbg)
//   - RESP_*       : AXI response codes
//   - ERR_TIMEOUT  : err_code reported when a channel wait times out
//   - ADDR_*       : default register map of the adder slave
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW_W = 3'd1,
        ST_B    = 3'd2,
        ST_AR   = 3'd3,
        ST_R    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A timeout shares the DECERR encoding on err_code.
    localparam logic [1:0] ERR_TIMEOUT = RESP_DECERR;

    localparam logic [7:0] ADDR_OPA  = 8'h00;
    localparam logic [7:0] ADDR_OPB  = 8'h04;
    localparam logic [7:0] ADDR_SUM  = 8'h08;
    localparam logic [7:0] ADDR_STAT = 8'h0C;

endpackage

// File: rtl/axil_wr_chan.sv
// axil_wr_chan: tracks the independent AW and W handshakes of one AXI4-Lite write.
//   clk, rst_n : clock, asynchronous active-low reset
//   launch     : raise awvalid and wvalid together (start of a write)
//   abort      : drop both valids immediately (timeout)
//   awready    : slave address-channel ready
//   wready     : slave data-channel ready
//   awvalid    : registered address-channel valid
//   wvalid     : registered data-channel valid
//   both_done  : both handshakes complete by the end of this cycle
// Each valid drops on its own handshake; both_done also covers the case where
// the last (or both) handshakes happen in the current cycle.
module axil_wr_chan (
    input  logic clk,
    input  logic rst_n,
    input  logic launch,
    input  logic abort,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (abort) begin
            active  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (launch) begin
            active  <= 1'b1;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (both_done)          active  <= 1'b0;
        end
    end

    // A channel counts as finished if its valid already dropped or it handshakes now.
    assign both_done = active && (!awvalid || awready) && (!wvalid || wready);

endmodule

// File: rtl/axil_adder_master.sv
// axil_adder_master: AXI4-Lite initiator driving the memory-mapped adder slave.
// A start strobe accepted in IDLE runs: write A, write B, read SUM, read STAT,
// then pulses done for one cycle with result/carry/err/err_code.
// Ports:
//   m1_axi_aclk, m1_axi_aresetn : clock, asynchronous active-low reset
//   start, op_a, op_b           : command strobe and operands (sampled on accept)
//   busy, done                  : command in flight / one-cycle completion pulse
//   result, carry               : captured sum and STAT bit0
//   err, err_code               : non-OKAY response (or timeout) and its code
//   m1_axi_aw*/w*/b*/ar*/r*     : AXI4-Lite master channels
//   state_dbg                   : current FSM state
// Build option: define AXIL_MASTER_TIMEOUT_EN to abort any channel wait that
// lasts TIMEOUT_CYCLES cycles (err_code = 2'b11). Without it the FSM waits forever.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; a valid, once raised, stays high with
// its payload stable until that edge, and ready/valid of the master are registered.
module axil_adder_master
    import axil_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] OPA_ADDR       = ADDR_WIDTH'(ADDR_OPA),
    parameter logic [ADDR_WIDTH-1:0] OPB_ADDR       = ADDR_WIDTH'(ADDR_OPB),
    parameter logic [ADDR_WIDTH-1:0] SUM_ADDR       = ADDR_WIDTH'(ADDR_SUM),
    parameter logic [ADDR_WIDTH-1:0] STAT_ADDR      = ADDR_WIDTH'(ADDR_STAT),
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                      m1_axi_aclk,
    input  logic                      m1_axi_aresetn,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      carry,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
    output logic                      m1_axi_awvalid,
    input  logic                      m1_axi_awready,
    output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
    output logic                      m1_axi_wvalid,
    input  logic                      m1_axi_wready,
    input  logic [1:0]                m1_axi_bresp,
    input  logic                      m1_axi_bvalid,
    output logic                      m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
    output logic                      m1_axi_arvalid,
    input  logic                      m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
    input  logic [1:0]                m1_axi_rresp,
    input  logic                      m1_axi_rvalid,
    output logic                      m1_axi_rready,
    output state_t                    state_dbg
);

    state_t                state;
    logic                  idx;      // 0: A write / SUM read, 1: B write / STAT read
    logic [DATA_WIDTH-1:0] op_b_q;
    logic                  wr_launch;
    logic                  wr_both_done;
    logic                  progress;
    logic                  waiting;
    logic                  timeout_fire;

    assign m1_axi_wstrb = '1;
    assign state_dbg    = state;

    // Does the current channel state complete its handshake this cycle?
    always_comb begin
        progress = 1'b0;
        waiting  = 1'b0;
        case (state)
            ST_AW_W: begin waiting = 1'b1; progress = wr_both_done; end
            ST_B:    begin waiting = 1'b1; progress = m1_axi_bvalid && m1_axi_bready; end
            ST_AR:   begin waiting = 1'b1; progress = m1_axi_arvalid && m1_axi_arready; end
            ST_R:    begin waiting = 1'b1; progress = m1_axi_rvalid && m1_axi_rready; end
            default: begin waiting = 1'b0; progress = 1'b0; end
        endcase
    end

    // Both writes are launched from here: the A write on accept, the B write
    // after an OKAY response to the A write.
    assign wr_launch = ((state == ST_IDLE) && start) ||
                       ((state == ST_B) && m1_axi_bvalid && m1_axi_bready &&
                        (m1_axi_bresp == RESP_OKAY) && !idx);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Every exit from a waiting state is a handshake or a timeout, so clearing
    // on those events restarts the count at each state entry.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn)                   wait_cnt <= '0;
        else if (!waiting || progress || timeout_fire) wait_cnt <= '0;
        else                                   wait_cnt <= wait_cnt + CW'(1);
    end

    assign timeout_fire = waiting && !progress && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_fire = 1'b0;
`endif

    axil_wr_chan u_wr_chan (
        .clk       (m1_axi_aclk),
        .rst_n     (m1_axi_aresetn),
        .launch    (wr_launch),
        .abort     (timeout_fire),
        .awready   (m1_axi_awready),
        .wready    (m1_axi_wready),
        .awvalid   (m1_axi_awvalid),
        .wvalid    (m1_axi_wvalid),
        .both_done (wr_both_done)
    );

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state          <= ST_IDLE;
            idx            <= 1'b0;
            op_b_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            carry          <= 1'b0;
            err            <= 1'b0;
            err_code       <= RESP_OKAY;
            m1_axi_awaddr  <= '0;
            m1_axi_wdata   <= '0;
            m1_axi_bready  <= 1'b0;
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
        end else if (timeout_fire) begin
            m1_axi_bready  <= 1'b0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
            err            <= 1'b1;
            err_code       <= ERR_TIMEOUT;
            idx            <= 1'b0;
            done           <= 1'b1;
            state          <= ST_DONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_b_q        <= op_b;
                        busy          <= 1'b1;
                        idx           <= 1'b0;
                        err           <= 1'b0;
                        err_code      <= RESP_OKAY;
                        m1_axi_awaddr <= OPA_ADDR;
                        m1_axi_wdata  <= op_a;
                        state         <= ST_AW_W;
                    end
                end
                ST_AW_W: begin
                    if (wr_both_done) begin
                        m1_axi_bready <= 1'b1;
                        state         <= ST_B;
                    end
                end
                ST_B: begin
                    if (m1_axi_bvalid && m1_axi_bready) begin
                        m1_axi_bready <= 1'b0;
                        if (m1_axi_bresp != RESP_OKAY) begin
                            err      <= 1'b1;
                            err_code <= m1_axi_bresp;
                            idx      <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else if (!idx) begin
                            idx           <= 1'b1;
                            m1_axi_awaddr <= OPB_ADDR;
                            m1_axi_wdata  <= op_b_q;
                            state         <= ST_AW_W;
                        end else begin
                            idx            <= 1'b0;
                            m1_axi_araddr  <= SUM_ADDR;
                            m1_axi_arvalid <= 1'b1;
                            state          <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m1_axi_arvalid && m1_axi_arready) begin
                        m1_axi_arvalid <= 1'b0;
                        m1_axi_rready  <= 1'b1;
                        state          <= ST_R;
                    end
                end
                ST_R: begin
                    if (m1_axi_rvalid && m1_axi_rready) begin
                        m1_axi_rready <= 1'b0;
                        if (m1_axi_rresp != RESP_OKAY) begin
                            err      <= 1'b1;
                            err_code <= m1_axi_rresp;
                            idx      <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else if (!idx) begin
                            result         <= m1_axi_rdata;
                            idx            <= 1'b1;
                            m1_axi_araddr  <= STAT_ADDR;
                            m1_axi_arvalid <= 1'b1;
                            state          <= ST_AR;
                        end else begin
                            carry <= m1_axi_rdata[0];
                            idx   <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_adder_master.sv
// tb_axil_adder_master: bench for axil_adder_master with a reactive adder
// slave model, a write scoreboard and a command-level reference model.
`timescale 1ns/1ps
module tb_axil_adder_master;
    import axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            start;
    logic [DW-1:0]   op_a, op_b;
    logic            busy, done, carry, err;
    logic [DW-1:0]   result;
    logic [1:0]      err_code;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, awready, wvalid, wready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
    logic            bvalid, bready, arvalid, arready, rvalid, rready;
    state_t          state_dbg;

    axil_adder_master dut (
        .m1_axi_aclk    (clk),
        .m1_axi_aresetn (rst_n),
        .start          (start),
        .op_a           (op_a),
        .op_b           (op_b),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .carry          (carry),
        .err            (err),
        .err_code       (err_code),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (bresp),
        .m1_axi_bvalid  (bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (rdata),
        .m1_axi_rresp   (rresp),
        .m1_axi_rvalid  (rvalid),
        .m1_axi_rready  (rready),
        .state_dbg      (state_dbg)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int            aw_delay = 0, w_delay = 0;
    bit            berr_first = 0;
    logic [1:0]    berr_code = 2'b00;
    bit            r_mute = 0;
    int            aw_cnt, w_cnt, wr_count;
    bit            have_aw, have_w;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    logic [AW+DW-1:0] wr_log[$];

    function automatic logic [DW-1:0] slave_read(input logic [AW-1:0] addr);
        logic [DW:0] s;
        s = {1'b0, reg_a} + {1'b0, reg_b};
        case (addr)
            8'h00:   return reg_a;
            8'h04:   return reg_b;
            8'h08:   return s[DW-1:0];
            8'h0C:   return {{(DW-1){1'b0}}, s[DW]};
            default: return '0;
        endcase
    endfunction

    task automatic slave_reset();
        awready = (aw_delay == 0);
        wready  = (w_delay == 0);
        arready = 1'b1;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        rvalid  = 1'b0;
        rresp   = 2'b00;
        rdata   = '0;
        have_aw = 0;
        have_w  = 0;
        aw_cnt  = 0;
        w_cnt   = 0;
    endtask

    task automatic set_slave(input int awd, input int wd, input bit be, input logic [1:0] code);
        aw_delay   = awd;
        w_delay    = wd;
        berr_first = be;
        berr_code  = code;
        aw_cnt     = 0;
        w_cnt      = 0;
        awready    = (awd == 0);
        wready     = (wd == 0);
    endtask

    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r;
        logic [AW-1:0] aw_s, ar_s;
        logic [DW-1:0] w_s;
        slave_reset();
        forever begin
            @(posedge clk);
            s_aw = awvalid && awready;
            s_w  = wvalid && wready;
            s_b  = bvalid && bready;
            s_ar = arvalid && arready;
            s_r  = rvalid && rready;
            aw_s = awaddr;
            w_s  = wdata;
            ar_s = araddr;
            #1;
            if (!rst_n) begin
                slave_reset();
                continue;
            end
            if (s_b) bvalid = 1'b0;
            if (s_r) rvalid = 1'b0;
            if (s_aw) begin have_aw = 1; pend_addr = aw_s; end
            if (s_w)  begin have_w = 1;  pend_data = w_s;  end
            if (aw_delay == 0)  awready = 1'b1;
            else if (s_aw)      begin aw_cnt = 0; awready = 1'b0; end
            else if (awvalid)   begin aw_cnt++; awready = (aw_cnt >= aw_delay); end
            if (w_delay == 0)   wready = 1'b1;
            else if (s_w)       begin w_cnt = 0; wready = 1'b0; end
            else if (wvalid)    begin w_cnt++; wready = (w_cnt >= w_delay); end
            if (have_aw && have_w) begin
                wr_log.push_back({pend_addr, pend_data});
                if (pend_addr == 8'h00) reg_a = pend_data;
                if (pend_addr == 8'h04) reg_b = pend_data;
                bvalid = 1'b1;
                bresp  = (berr_first && wr_count == 0) ? berr_code : 2'b00;
                wr_count++;
                have_aw = 0;
                have_w  = 0;
            end
            if (s_ar && !r_mute) begin
                rvalid = 1'b1;
                rdata  = slave_read(ar_s);
                rresp  = 2'b00;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int            aw_hi, w_hi;
    bit            aw_pend, w_pend;
    logic [AW-1:0] last_awaddr;
    logic [DW-1:0] last_wdata;

    initial begin
        aw_hi = 0; w_hi = 0; aw_pend = 0; w_pend = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                aw_pend = 0;
                w_pend  = 0;
            end else begin
                if (awvalid) aw_hi++;
                if (wvalid)  w_hi++;
                if (aw_pend) begin
                    check("awvalid_held", awvalid, 1);
                    check("awaddr_stable", awaddr, last_awaddr);
                end
                if (w_pend) begin
                    check("wvalid_held", wvalid, 1);
                    check("wdata_stable", wdata, last_wdata);
                end
                if (awvalid || arvalid) check("aw_ar_excl", awvalid && arvalid, 0);
                aw_pend     = awvalid && !awready;
                w_pend      = wvalid && !wready;
                last_awaddr = awaddr;
                last_wdata  = wdata;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    model_result = '0;
    logic             model_carry  = 1'b0;

    task automatic compare_writes();
        logic [AW+DW-1:0] e, g;
        check("wr_count", wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_log.pop_front();
            check("wr_addr_data", g, e);
        end
        exp_q.delete();
        wr_log.delete();
    endtask

    // One command: model predicts writes, result/carry, err and cycle counts.
    task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit junk);
        int lat, exp_lat, ch, nwr;
        logic [DW:0] full;
        bit bad;
        bad = berr_first;
        nwr = bad ? 1 : 2;
        ch  = (aw_delay > w_delay) ? aw_delay : w_delay;
        if (ch < 1) ch = 1;
        exp_q.push_back({8'h00, a});
        if (!bad) exp_q.push_back({8'h04, b});
        full = {1'b0, a} + {1'b0, b};
        if (!bad) begin
            model_result = full[DW-1:0];
            model_carry  = full[DW];
            exp_lat      = 2 * ch + 6;
        end else begin
            exp_lat = ch + 1;
        end
        wr_count = 0;
        aw_hi = 0;
        w_hi  = 0;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        check("busy_accept", busy, 1);
        lat = 0;
        while (!done && lat < 200) begin
            start = junk && (lat == 1);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency", lat, exp_lat);
        check("err", err, bad);
        check("err_code", err_code, bad ? berr_code : 2'b00);
        check("result", result, model_result);
        check("carry", carry, model_carry);
        check("busy_in_done", busy, 1);
        check("aw_cycles", aw_hi, nwr * ((aw_delay < 1) ? 1 : aw_delay));
        check("w_cycles", w_hi, nwr * ((w_delay < 1) ? 1 : w_delay));
        compare_writes();
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_clear", busy, 0);
        check("err_hold", err, bad);
        check("result_hold", result, model_result);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [DW-1:0] ra, rb;
        start = 1'b0; op_a = '0; op_b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 4'hF);
        check("rst_state", state_dbg, ST_IDLE);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed: zero-wait, carry, AW backpressure, write error.
        set_slave(0, 0, 0, 2'b00);
        run_cmd(32'h0000_AABB, 32'h0000_CCDD, 0);
        check("dir1_sum", result, 32'h0001_7798);
        run_cmd(32'hFFFF_FFFF, 32'h0000_0001, 0);
        check("dir2_carry", carry, 1);
        set_slave(3, 0, 0, 2'b00);
        run_cmd(32'h1234_5678, 32'h0BAD_F00D, 0);
        set_slave(0, 0, 1, 2'b10);
        run_cmd(32'h0000_0005, 32'h0000_0007, 0);

        // Reset during AR, then a clean command.
        set_slave(0, 0, 0, 2'b00);
        wr_count = 0;
        @(negedge clk);
        op_a = 32'h0000_1111; op_b = 32'h0000_2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!arvalid && n < 50) begin @(posedge clk); #1; n++; end
        check("ar_reached", arvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ar_arvalid", arvalid, 0);
        check("rst_ar_busy", busy, 0);
        check("rst_ar_state", state_dbg, ST_IDLE);
        model_result = '0;
        model_carry  = 1'b0;
        check("rst_ar_result", result, model_result);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        wr_log.delete();
        run_cmd(32'h8000_0000, 32'h8000_0001, 0);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Read data never returned: the R wait must time out.
        r_mute = 1;
        wr_count = 0;
        @(negedge clk);
        op_a = 32'h0000_0003; op_b = 32'h0000_0004; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!rready && n < 50) begin @(posedge clk); #1; n++; end
        check("to_r_reached", rready, 1);
        n = 0;
        while (!done && n < 2 * TO) begin @(posedge clk); #1; n++; end
        check("to_done", done, 1);
        check("to_wait", n, TO);
        check("to_err", err, 1);
        check("to_err_code", err_code, 2'b11);
        check("to_rready", rready, 0);
        check("to_result_hold", result, model_result);
        @(posedge clk); #1;
        r_mute = 0;
        exp_q.delete();
        wr_log.delete();
`endif

        // Randomized commands with random backpressure and write errors.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0)
                set_slave($urandom_range(0, 3), $urandom_range(0, 3), 1,
                          2'($urandom_range(1, 3)));
            else
                set_slave($urandom_range(0, 3), $urandom_range(0, 3), 0, 2'b00);
            run_cmd(ra, rb, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
